// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_pkg
// Description : Shared widths and the prediction-metadata record carried down
//               the IF/ID and ID/EX stages of the branch resolve unit.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

    localparam int XLEN      = 32;
    localparam int PHT_IDX_W = 5;
    localparam int CNT_W     = 16;

    // Prediction metadata for one in-flight instruction
    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      pred_next_pc;
        logic [PHT_IDX_W-1:0] pht_index;
    } pred_meta_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_pred_meta_reg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_pred_meta_reg
// Description : One pipeline stage register for prediction metadata, with
//               flush (kill), hold (stall) and bubble (insert invalid) controls.
//               Priority: reset > flush > hold > bubble > load.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit_pred_meta_reg
    import branch_resolve_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush_i,
    input  logic       hold_i,
    input  logic       bubble_i,
    input  pred_meta_t d_i,
    output pred_meta_t q_o
);

    pred_meta_t meta_q;
    pred_meta_t meta_d;

    // Next-state selection; killed/bubbled entries keep stale payload, only valid drops
    always_comb begin
        meta_d = meta_q;
        if (flush_i) begin
            meta_d.valid = 1'b0;
        end else if (hold_i) begin
            meta_d = meta_q;
        end else if (bubble_i) begin
            meta_d.valid = 1'b0;
        end else begin
            meta_d = d_i;
        end
    end

    // Stage register with synchronous reset clearing every field
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
        end else begin
            meta_q <= meta_d;
        end
    end

    assign q_o = meta_q;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Carries predictor metadata from IF to EX, resolves control flow
//               in EX, produces the gshare update bundle, flush/redirect on
//               misprediction, and saturating branch/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_valid,
    input  logic [XLEN-1:0]      if_pc,
    input  logic [XLEN-1:0]      if_pred_next_pc,
    input  logic [PHT_IDX_W-1:0] if_pht_index,
    input  logic                 stall,
    input  logic                 id_is_branch,
    input  logic                 id_is_jal,
    input  logic                 id_is_jalr,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [XLEN-1:0]      ex_rs1_data,
    input  logic                 ex_bcond,
    output logic                 is_branch,
    output logic                 is_jal,
    output logic                 is_jalr,
    output logic                 actual_taken,
    output logic [XLEN-1:0]      actual_branch_target,
    output logic                 prediction_correct,
    output logic [PHT_IDX_W-1:0] pht_update_index,
    output logic [XLEN-1:0]      ID_EX_pc,
    output logic                 flush,
    output logic [XLEN-1:0]      redirect_pc,
    output logic [CNT_W-1:0]     branch_count,
    output logic [CNT_W-1:0]     mispredict_count
);

    pred_meta_t          w_if_meta;
    pred_meta_t          w_ifid_meta;
    pred_meta_t          w_idex_meta;

    logic                is_branch_q;
    logic                is_jal_q;
    logic                is_jalr_q;
    logic [XLEN-1:0]     imm_q;

    logic                w_v;
    logic                w_taken;
    logic [XLEN-1:0]     w_pc_plus4;
    logic [XLEN-1:0]     w_jalr_sum;
    logic [XLEN-1:0]     w_target;
    logic [XLEN-1:0]     w_actual_next;
    logic                w_correct;
    logic                w_flush;

    logic [CNT_W-1:0]    branch_cnt_q;
    logic [CNT_W-1:0]    branch_cnt_d;
    logic [CNT_W-1:0]    mispredict_cnt_q;
    logic [CNT_W-1:0]    mispredict_cnt_d;

    assign w_if_meta = '{valid:        if_valid,
                         pc:           if_pc,
                         pred_next_pc: if_pred_next_pc,
                         pht_index:    if_pht_index};

    // IF/ID holds on stall; never bubbles itself
    branch_resolve_unit_pred_meta_reg u_if_id_meta (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (w_flush),
        .hold_i   (stall),
        .bubble_i (1'b0),
        .d_i      (w_if_meta),
        .q_o      (w_ifid_meta)
    );

    // ID/EX takes a bubble on stall; never holds
    branch_resolve_unit_pred_meta_reg u_id_ex_meta (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (w_flush),
        .hold_i   (1'b0),
        .bubble_i (stall),
        .d_i      (w_ifid_meta),
        .q_o      (w_idex_meta)
    );

    // ID/EX decode fields; only meaningful while the ID/EX valid bit is set
    always_ff @(posedge clk) begin
        if (reset) begin
            is_branch_q <= 1'b0;
            is_jal_q    <= 1'b0;
            is_jalr_q   <= 1'b0;
            imm_q       <= '0;
        end else if (!w_flush && !stall) begin
            is_branch_q <= id_is_branch;
            is_jal_q    <= id_is_jal;
            is_jalr_q   <= id_is_jalr;
            imm_q       <= id_imm;
        end
    end

    // EX resolution: direction, target, actual next PC and prediction check
    always_comb begin
        w_v        = w_idex_meta.valid;
        w_pc_plus4 = w_idex_meta.pc + XLEN'(4);
        w_jalr_sum = ex_rs1_data + imm_q;
        if (is_jalr_q) begin
            w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            w_target = w_idex_meta.pc + imm_q;
        end
        if (is_branch_q) begin
            w_taken = ex_bcond;
        end else begin
            w_taken = is_jal_q | is_jalr_q;
        end
        w_actual_next = w_taken ? w_target : w_pc_plus4;
        // A valid non-control instruction predicted taken (BTB alias) also fails here
        w_correct     = !w_v || (w_idex_meta.pred_next_pc == w_actual_next);
        w_flush       = w_v && !w_correct;
    end

    // Saturating performance counter next-state
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (w_v && (is_branch_q || is_jal_q || is_jalr_q) && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (w_flush && (mispredict_cnt_q != '1)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
        end
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign is_branch            = w_v & is_branch_q;
    assign is_jal               = w_v & is_jal_q;
    assign is_jalr              = w_v & is_jalr_q;
    assign actual_taken         = w_v & w_taken;
    assign actual_branch_target = w_target;
    assign prediction_correct   = w_correct;
    assign pht_update_index     = w_idex_meta.pht_index;
    assign ID_EX_pc             = w_idex_meta.pc;
    assign flush                = w_flush;
    assign redirect_pc          = w_actual_next;
    assign branch_count         = branch_cnt_q;
    assign mispredict_count     = mispredict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench for branch_resolve_unit: directed vector
//               table, hand sequences for stall/flush/saturation/reset, and
//               randomized traffic against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_pred_next_pc = '0;
    logic [4:0]  if_pht_index = '0;
    logic        stall = 1'b0;
    logic        id_is_branch = 1'b0;
    logic        id_is_jal = 1'b0;
    logic        id_is_jalr = 1'b0;
    logic [31:0] id_imm = '0;
    logic [31:0] ex_rs1_data = '0;
    logic        ex_bcond = 1'b0;

    logic        is_branch, is_jal, is_jalr, actual_taken;
    logic [31:0] actual_branch_target, ID_EX_pc, redirect_pc;
    logic        prediction_correct, flush;
    logic [4:0]  pht_update_index;
    logic [15:0] branch_count, mispredict_count;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .if_valid             (if_valid),
        .if_pc                (if_pc),
        .if_pred_next_pc      (if_pred_next_pc),
        .if_pht_index         (if_pht_index),
        .stall                (stall),
        .id_is_branch         (id_is_branch),
        .id_is_jal            (id_is_jal),
        .id_is_jalr           (id_is_jalr),
        .id_imm               (id_imm),
        .ex_rs1_data          (ex_rs1_data),
        .ex_bcond             (ex_bcond),
        .is_branch            (is_branch),
        .is_jal               (is_jal),
        .is_jalr              (is_jalr),
        .actual_taken         (actual_taken),
        .actual_branch_target (actual_branch_target),
        .prediction_correct   (prediction_correct),
        .pht_update_index     (pht_update_index),
        .ID_EX_pc             (ID_EX_pc),
        .flush                (flush),
        .redirect_pc          (redirect_pc),
        .branch_count         (branch_count),
        .mispredict_count     (mispredict_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one record per in-flight instruction
    typedef struct {
        bit        valid;
        bit [31:0] pc;
        bit [31:0] pred;
        bit [4:0]  idx;
        bit        br, jal, jalr;
        bit [31:0] imm;
    } inst_t;

    inst_t m_ifid, m_idex;
    int    m_bcnt, m_mcnt;

    function automatic bit [31:0] ref_target(inst_t i, bit [31:0] rs1);
        if (i.jalr) return (rs1 + i.imm) & 32'hFFFF_FFFE;
        return i.pc + i.imm;
    endfunction

    function automatic bit ref_taken(inst_t i, bit bcond);
        if (i.br) return bcond;
        return i.jal | i.jalr;
    endfunction

    function automatic bit [31:0] ref_next(inst_t i, bit [31:0] rs1, bit bcond);
        return ref_taken(i, bcond) ? ref_target(i, rs1) : i.pc + 32'd4;
    endfunction

    function automatic bit ref_mispredict(inst_t i, bit [31:0] rs1, bit bcond);
        return i.valid && (i.pred != ref_next(i, rs1, bcond));
    endfunction

    task automatic model_check();
        bit v = m_idex.valid;
        chk("is_branch", is_branch, v & m_idex.br);
        chk("is_jal", is_jal, v & m_idex.jal);
        chk("is_jalr", is_jalr, v & m_idex.jalr);
        chk("actual_taken", actual_taken, v & ref_taken(m_idex, ex_bcond));
        chk("prediction_correct", prediction_correct, !ref_mispredict(m_idex, ex_rs1_data, ex_bcond));
        chk("flush", flush, ref_mispredict(m_idex, ex_rs1_data, ex_bcond));
        if (v) begin
            chk("actual_branch_target", actual_branch_target, ref_target(m_idex, ex_rs1_data));
            chk("redirect_pc", redirect_pc, ref_next(m_idex, ex_rs1_data, ex_bcond));
            chk("pht_update_index", pht_update_index, m_idex.idx);
            chk("ID_EX_pc", ID_EX_pc, m_idex.pc);
        end
        chk("branch_count", branch_count, m_bcnt);
        chk("mispredict_count", mispredict_count, m_mcnt);
    endtask

    task automatic model_reset();
        m_ifid = '{default: 0};
        m_idex = '{default: 0};
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    task automatic model_step();
        bit mp = ref_mispredict(m_idex, ex_rs1_data, ex_bcond);
        if (reset) begin
            model_reset();
        end else begin
            if (m_idex.valid && (m_idex.br || m_idex.jal || m_idex.jalr) && m_bcnt < 65535) m_bcnt++;
            if (mp && m_mcnt < 65535) m_mcnt++;
            if (mp) begin
                m_ifid.valid = 0;
                m_idex.valid = 0;
            end else if (stall) begin
                m_idex.valid = 0;
            end else begin
                m_idex      = m_ifid;
                m_idex.br   = id_is_branch;
                m_idex.jal  = id_is_jal;
                m_idex.jalr = id_is_jalr;
                m_idex.imm  = id_imm;
                m_ifid = '{valid: if_valid, pc: if_pc, pred: if_pred_next_pc, idx: if_pht_index,
                           br: 0, jal: 0, jalr: 0, imm: 0};
            end
        end
    endtask

    // Inputs are applied at the negedge; compare mid-cycle, then advance one clock
    task automatic cycle();
        #1;
        model_check();
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_valid = 0; if_pc = 0; if_pred_next_pc = 0; if_pht_index = 0;
        stall = 0; id_is_branch = 0; id_is_jal = 0; id_is_jalr = 0; id_imm = 0;
        ex_rs1_data = 0; ex_bcond = 0;
    endtask

    // ---------------- directed vector table
    typedef struct {
        string     name;
        bit [1:0]  kind;      // 0 none, 1 branch, 2 jal, 3 jalr
        bit [31:0] pc, imm, rs1, pred;
        bit [4:0]  idx;
        bit        bcond;
        bit        e_taken;
        bit [31:0] e_target;
        bit        e_correct;
        bit [31:0] e_redirect;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input vec_t t);
        if_valid = 1; if_pc = t.pc; if_pred_next_pc = t.pred; if_pht_index = t.idx;
        cycle();
        if_valid = 0; if_pc = 0; if_pred_next_pc = 0; if_pht_index = 0;
        id_is_branch = (t.kind == 2'd1); id_is_jal = (t.kind == 2'd2); id_is_jalr = (t.kind == 2'd3);
        id_imm = t.imm;
        cycle();
        id_is_branch = 0; id_is_jal = 0; id_is_jalr = 0; id_imm = 0;
        ex_rs1_data = t.rs1; ex_bcond = t.bcond;
        #1;
        chk({t.name, ".is_branch"}, is_branch, t.kind == 2'd1);
        chk({t.name, ".is_jal"}, is_jal, t.kind == 2'd2);
        chk({t.name, ".is_jalr"}, is_jalr, t.kind == 2'd3);
        chk({t.name, ".taken"}, actual_taken, t.e_taken);
        chk({t.name, ".target"}, actual_branch_target, t.e_target);
        chk({t.name, ".correct"}, prediction_correct, t.e_correct);
        chk({t.name, ".flush"}, flush, !t.e_correct);
        chk({t.name, ".redirect"}, redirect_pc, t.e_redirect);
        chk({t.name, ".pht_idx"}, pht_update_index, t.idx);
        chk({t.name, ".pc"}, ID_EX_pc, t.pc);
        cycle();
        ex_rs1_data = 0; ex_bcond = 0;
    endtask

    initial begin
        //             name        kind pc            imm           rs1           pred          idx    bc tk target        ok redirect
        vecs[0] = '{"br_mispred", 2'd1, 32'h40,       32'h20,       32'h0,        32'h44,       5'h01, 1, 1, 32'h60,       0, 32'h60};
        vecs[1] = '{"jalr_hit",   2'd3, 32'h80,       32'h4,        32'h1003,     32'h1006,     5'h02, 0, 1, 32'h1006,     1, 32'h1006};
        vecs[2] = '{"alias_add",  2'd0, 32'h10,       32'h0,        32'h0,        32'h30,       5'h03, 0, 0, 32'h10,       0, 32'h14};
        vecs[3] = '{"br_nt_hit",  2'd1, 32'h100,      32'h40,       32'h0,        32'h104,      5'h04, 0, 0, 32'h140,      1, 32'h104};
        vecs[4] = '{"jal_back",   2'd2, 32'h200,      32'hFFFF_FFF0, 32'h0,       32'h1F0,      5'h05, 0, 1, 32'h1F0,      1, 32'h1F0};
        vecs[5] = '{"jal_wrap",   2'd2, 32'hFFFF_FFF0, 32'h20,      32'h0,        32'h0,        5'h06, 0, 1, 32'h10,       0, 32'h10};
        vecs[6] = '{"br_tk_hit",  2'd1, 32'h300,      32'h8,        32'h0,        32'h308,      5'h1F, 1, 1, 32'h308,      1, 32'h308};
        vecs[7] = '{"jalr_wrap",  2'd3, 32'h400,      32'h2,        32'hFFFF_FFFF, 32'h404,     5'h07, 0, 1, 32'h0,        0, 32'h0};
        vecs[8] = '{"seq_wrap",   2'd0, 32'hFFFF_FFFC, 32'h0,       32'h0,        32'h0,        5'h08, 0, 0, 32'hFFFF_FFFC, 1, 32'h0};

        // Bring-up reset; state is unknown until it has been applied
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        #1;
        chk("rst.is_branch", is_branch, 0);
        chk("rst.flush", flush, 0);
        chk("rst.correct", prediction_correct, 1);
        chk("rst.branch_count", branch_count, 0);
        chk("rst.mispredict_count", mispredict_count, 0);
        chk("rst.pht_idx", pht_update_index, 0);
        chk("rst.ID_EX_pc", ID_EX_pc, 0);
        reset = 0;
        @(negedge clk);

        // Directed vectors with counter checkpoints after the first three
        run_vec(vecs[0]);
        #1;
        chk("after_br.is_branch", is_branch, 0);
        chk("after_br.correct", prediction_correct, 1);
        chk("after_br.mispredict_count", mispredict_count, 1);
        chk("after_br.branch_count", branch_count, 1);
        run_vec(vecs[1]);
        #1;
        chk("after_jalr.branch_count", branch_count, 2);
        chk("after_jalr.mispredict_count", mispredict_count, 1);
        run_vec(vecs[2]);
        #1;
        chk("after_alias.branch_count", branch_count, 2);
        chk("after_alias.mispredict_count", mispredict_count, 2);
        for (int i = 3; i < 9; i++) run_vec(vecs[i]);

        // Stall with a branch in IF/ID: bubble first, then the branch with its index intact
        if_valid = 1; if_pc = 32'h500; if_pred_next_pc = 32'h504; if_pht_index = 5'h1B;
        cycle();
        if_valid = 0; if_pc = 0; if_pred_next_pc = 0; if_pht_index = 0;
        stall = 1; id_is_branch = 1; id_imm = 32'h10;
        cycle();
        stall = 0;
        #1;
        chk("stall.bubble_is_branch", is_branch, 0);
        chk("stall.bubble_correct", prediction_correct, 1);
        chk("stall.bubble_flush", flush, 0);
        cycle();
        id_is_branch = 0; id_imm = 0; ex_bcond = 0;
        #1;
        chk("stall.late_is_branch", is_branch, 1);
        chk("stall.late_pht_idx", pht_update_index, 5'h1B);
        chk("stall.late_pc", ID_EX_pc, 32'h500);
        chk("stall.late_correct", prediction_correct, 1);
        cycle();

        // Stall coinciding with a flush: the held IF/ID instruction must die
        if_valid = 1; if_pc = 32'h600; if_pred_next_pc = 32'h604; if_pht_index = 5'h03;
        cycle();
        if_pc = 32'h604; if_pred_next_pc = 32'h608; if_pht_index = 5'h04;
        id_is_jal = 1; id_imm = 32'h40;
        cycle();
        if_valid = 0; if_pc = 0; if_pred_next_pc = 0; if_pht_index = 0;
        id_is_jal = 0; stall = 1; id_is_branch = 1; id_imm = 32'h8;
        #1;
        chk("sf.flush", flush, 1);
        chk("sf.redirect", redirect_pc, 32'h640);
        cycle();
        stall = 0;
        #1;
        chk("sf.next_flush", flush, 0);
        chk("sf.next_is_jal", is_jal, 0);
        chk("sf.next_is_branch", is_branch, 0);
        cycle();
        id_is_branch = 0; id_imm = 0;
        #1;
        chk("sf.held_never_in_ex", is_branch, 0);
        cycle();

        // Mispredict counter saturation
        force dut.mispredict_cnt_q = 16'hFFFE;
        #1;
        release dut.mispredict_cnt_q;
        m_mcnt = 16'hFFFE;
        @(negedge clk);
        for (int i = 0; i < 3; i++) run_vec(vecs[0]);
        #1;
        chk("sat.mispredict_count", mispredict_count, 16'hFFFF);

        // Reset while a flush is being signalled
        if_valid = 1; if_pc = 32'h40; if_pred_next_pc = 32'h44; if_pht_index = 5'h09;
        cycle();
        if_valid = 0; id_is_branch = 1; id_imm = 32'h20;
        cycle();
        id_is_branch = 0; id_imm = 0; ex_bcond = 1; reset = 1;
        #1;
        chk("rstflush.flush_before", flush, 1);
        cycle();
        reset = 0; ex_bcond = 0;
        #1;
        chk("rstflush.branch_count", branch_count, 0);
        chk("rstflush.mispredict_count", mispredict_count, 0);
        chk("rstflush.flush", flush, 0);
        chk("rstflush.correct", prediction_correct, 1);
        chk("rstflush.is_branch", is_branch, 0);
        chk("rstflush.taken", actual_taken, 0);
        chk("rstflush.pht_idx", pht_update_index, 0);
        chk("rstflush.pc", ID_EX_pc, 0);
        cycle();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [1:0] k;
            reset           = ($urandom_range(0, 63) == 0);
            stall           = ($urandom_range(0, 7) == 0);
            if_valid        = ($urandom_range(0, 3) != 0);
            if_pc           = {$urandom_range(0, 255), 2'b00};
            case ($urandom_range(0, 3))
                0, 1:    if_pred_next_pc = if_pc + 32'd4;
                2:       if_pred_next_pc = if_pc + {$urandom_range(0, 15), 2'b00};
                default: if_pred_next_pc = $urandom;
            endcase
            if_pht_index    = 5'($urandom);
            k               = 2'($urandom);
            id_is_branch    = (k == 2'd1);
            id_is_jal       = (k == 2'd2);
            id_is_jalr      = (k == 2'd3);
            id_imm          = {$urandom_range(0, 15), 2'b00};
            ex_rs1_data     = ($urandom_range(0, 1) == 0) ? $urandom : {$urandom_range(0, 255), 2'b01};
            ex_bcond        = 1'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
